// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results and runs byte-serial loads and stores
// on the shared 8-bit RAM port, stalling the pipeline until the access completes.
package mem_stage_pkg;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 3;

  localparam logic [ALU_OP_W-1:0] OP_LB  = 8'h20;
  localparam logic [ALU_OP_W-1:0] OP_LH  = 8'h21;
  localparam logic [ALU_OP_W-1:0] OP_LW  = 8'h23;
  localparam logic [ALU_OP_W-1:0] OP_LBU = 8'h24;
  localparam logic [ALU_OP_W-1:0] OP_LHU = 8'h25;
  localparam logic [ALU_OP_W-1:0] OP_SB  = 8'h28;
  localparam logic [ALU_OP_W-1:0] OP_SH  = 8'h29;
  localparam logic [ALU_OP_W-1:0] OP_SW  = 8'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      data_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic                  mem_gnt_i,
  input  logic [BYTE_W-1:0]     mem_din_i,
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_a_o,
  output logic [BYTE_W-1:0]     mem_dout_o,
  output logic                  mem_wr_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  stall_req_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ic_q, ic_d;
  logic [CNT_W-1:0]  rc_q, rc_d;
  logic [REG_W-1:0]  rbuf_q, rbuf_d;
  logic              pend_q, pend_d;

  logic              is_load, is_store, sign_ext;
  logic [CNT_W-1:0]  len;
  logic [REG_W-1:0]  ld_data;
  logic [4:0]        ic_bit, rc_bit;

  logic                  req_c, issue_c, wr_c, stall_c, wreg_c;
  logic [BYTE_W-1:0]     dout_c;
  logic [REG_ADDR_W-1:0] wd_c;
  logic [REG_W-1:0]      wdata_c;
  logic [ADDR_W-1:0]     addr_c;

  // Opcode decode: direction, transfer length and extension mode.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    len      = 3'd0;
    case (aluop_i)
      OP_LB:   begin is_load  = 1'b1; len = 3'd1; sign_ext = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; len = 3'd1; end
      OP_LH:   begin is_load  = 1'b1; len = 3'd2; sign_ext = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; len = 3'd2; end
      OP_LW:   begin is_load  = 1'b1; len = 3'd4; end
      OP_SB:   begin is_store = 1'b1; len = 3'd1; end
      OP_SH:   begin is_store = 1'b1; len = 3'd2; end
      OP_SW:   begin is_store = 1'b1; len = 3'd4; end
      default: ;
    endcase
  end

  // Extension of the assembled little-endian load data.
  always_comb begin
    case (len)
      3'd1:    ld_data = sign_ext ? {{24{rbuf_q[7]}}, rbuf_q[7:0]}
                                  : {24'h0, rbuf_q[7:0]};
      3'd2:    ld_data = sign_ext ? {{16{rbuf_q[15]}}, rbuf_q[15:0]}
                                  : {16'h0, rbuf_q[15:0]};
      default: ld_data = rbuf_q;
    endcase
  end

  assign ic_bit = {ic_q[1:0], 3'b000};
  assign rc_bit = {rc_q[1:0], 3'b000};

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ic_d    = ic_q;
    rc_d    = rc_q;
    rbuf_d  = rbuf_q;
    pend_d  = 1'b0;
    req_c   = 1'b0;
    issue_c = 1'b0;
    wr_c    = 1'b0;
    stall_c = 1'b0;
    wreg_c  = 1'b0;
    dout_c  = '0;
    wd_c    = '0;
    wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (is_load) begin
          state_d = ST_RD;
        end else if (is_store) begin
          state_d = ST_WR;
        end else begin
          wd_c    = wd_i;
          wreg_c  = wreg_i;
          wdata_c = data_i;
        end
      end
      ST_DONE: begin
        wd_c    = wd_i;
        wreg_c  = is_load ? wreg_i : 1'b0;
        wdata_c = is_load ? ld_data : '0;
        state_d = ST_IDLE;
        ic_d    = '0;
        rc_d    = '0;
      end
      default: ;
    endcase

    // Issue and receive are shared by the first cycle and the RD/WR states.
    if (state_q != ST_DONE && (is_load || is_store)) begin
      stall_c = 1'b1;
      req_c   = (ic_q < len);
      issue_c = req_c & mem_gnt_i;
      if (issue_c) begin
        ic_d   = ic_q + 3'd1;
        pend_d = is_load;
        if (is_store) begin
          wr_c   = 1'b1;
          dout_c = data_i[ic_bit +: BYTE_W];
          if (ic_q + 3'd1 == len) state_d = ST_DONE;
        end
      end
      // A byte issued last cycle arrives now, granted or not.
      if (pend_q) begin
        rbuf_d[rc_bit +: BYTE_W] = mem_din_i;
        rc_d = rc_q + 3'd1;
        if (rc_q + 3'd1 == len) state_d = ST_DONE;
      end
    end
  end

  assign addr_c = req_c ? (mem_addr_i + ADDR_W'(ic_q)) : '0;

  // Reset blanks every output, suppressing any in-flight write.
  assign mem_req_o   = ~rst & req_c;
  assign mem_wr_o    = ~rst & wr_c;
  assign stall_req_o = ~rst & stall_c;
  assign wreg_o      = ~rst & wreg_c;
  assign mem_a_o     = rst ? '0 : addr_c;
  assign mem_dout_o  = rst ? '0 : dout_c;
  assign wd_o        = rst ? '0 : wd_c;
  assign wdata_o     = rst ? '0 : wdata_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ic_q    <= '0;
      rc_q    <= '0;
      rbuf_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      rc_q    <= rc_d;
      rbuf_q  <= rbuf_d;
      pend_q  <= pend_d;
    end
  end

endmodule
